// File: rtl/chan_rx_arbiter.sv
// Round-robin merge of NCHAN per-channel AXI-Stream receive streams into one
// output stream, holding each grant for a whole packet and flagging stalls.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   enable_mask        per-channel arbitration enable
//   s_axis_rx_*        per-channel input streams (16-bit data, 2-bit keep)
//   m_axis_*           merged output stream; m_axis_tchan = granted channel
//   clear_err          pulse clearing the sticky stall flags
//   stall_err          per-channel sticky mid-packet stall flags
//   busy               high while a packet is being forwarded

module chan_rx_arbiter #(
    parameter int NCHAN     = 5,
    parameter int STALL_MAX = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCHAN-1:0]     enable_mask,
    input  logic [16*NCHAN-1:0]  s_axis_rx_tdata,
    input  logic [2*NCHAN-1:0]   s_axis_rx_tkeep,
    input  logic [NCHAN-1:0]     s_axis_rx_tvalid,
    input  logic [NCHAN-1:0]     s_axis_rx_tlast,
    output logic [NCHAN-1:0]     s_axis_rx_tready,
    output logic [0:15]          m_axis_tdata,
    output logic [0:1]           m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic [2:0]           m_axis_tchan,
    input  logic                 m_axis_tready,
    input  logic                 clear_err,
    output logic [NCHAN-1:0]     stall_err,
    output logic                 busy
);

    localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int CW = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STALL_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    g_q, g_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NCHAN-1:0] err_q, err_d;

    logic [NCHAN-1:0] elig;
    logic [IW-1:0]    sel;
    logic             found;
    int               idx;
    logic             g_valid;
    logic             g_last;
    logic             beat_fire;

    assign elig = enable_mask & s_axis_rx_tvalid;

    // First eligible channel starting at rr_q, wrapping modulo NCHAN.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NCHAN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    assign g_valid   = s_axis_rx_tvalid[g_q];
    assign g_last    = s_axis_rx_tlast[g_q];
    assign beat_fire = (state_q == XFER) && g_valid && m_axis_tready;

    // Output mux: slice bit 16g+k lands on m_axis_tdata[k] (same for keep).
    always_comb begin
        m_axis_tdata     = '0;
        m_axis_tkeep     = '0;
        s_axis_rx_tready = '0;
        for (int k = 0; k < 16; k++) begin
            m_axis_tdata[k] = s_axis_rx_tdata[16*int'(g_q) + k];
        end
        for (int k = 0; k < 2; k++) begin
            m_axis_tkeep[k] = s_axis_rx_tkeep[2*int'(g_q) + k];
        end
        m_axis_tvalid = (state_q == XFER) && g_valid;
        m_axis_tlast  = (state_q == XFER) && g_last;
        if (state_q == XFER) begin
            s_axis_rx_tready[g_q] = m_axis_tready;
        end
    end

    assign m_axis_tchan = 3'(g_q);
    assign stall_err    = err_q;
    assign busy         = (state_q == XFER);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        err_d   = clear_err ? '0 : err_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = sel;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (g_valid) begin
                    cnt_d = '0;
                end else if (cnt_q != SMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Flag on the edge where the count reaches the limit, and
                // keep re-asserting while saturated so it beats clear_err.
                if (!g_valid && (cnt_q >= SMAX - CW'(1))) begin
                    err_d[g_q] = 1'b1;
                end
                if (beat_fire && g_last) begin
                    state_d = IDLE;
                    rr_d    = (int'(g_q) == NCHAN - 1) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_chan_rx_arbiter.sv
// Directed self-checking bench for chan_rx_arbiter (NCHAN=5, STALL_MAX=8).
// Per-channel packet sources feed the DUT; merged beats are checked.

module tb_chan_rx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  enable_mask;
    logic [79:0] s_tdata;
    logic [9:0]  s_tkeep;
    logic [4:0]  s_tvalid;
    logic [4:0]  s_tlast;
    logic [4:0]  s_tready;
    logic [0:15] m_tdata;
    logic [0:1]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic [2:0]  m_tchan;
    logic        m_tready;
    logic        clear_err;
    logic [4:0]  stall_err;
    logic        busy;

    chan_rx_arbiter #(.NCHAN(5), .STALL_MAX(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable_mask      (enable_mask),
        .s_axis_rx_tdata  (s_tdata),
        .s_axis_rx_tkeep  (s_tkeep),
        .s_axis_rx_tvalid (s_tvalid),
        .s_axis_rx_tlast  (s_tlast),
        .s_axis_rx_tready (s_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tlast     (m_tlast),
        .m_axis_tchan     (m_tchan),
        .m_axis_tready    (m_tready),
        .clear_err        (clear_err),
        .stall_err        (stall_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int plen[5];
    int npk[5];
    int beat[5];
    int pkn[5];
    logic [4:0] hold;
    int q_last[$];
    int nbeats;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] slice(input int c);
        return {4'hA, 4'(c), 4'(pkn[c]), 4'(beat[c])};
    endfunction

    function automatic logic [1:0] keep_of(input int c);
        return beat[c][0] ? 2'b10 : 2'b11;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[15-k] = v[k];
        return r;
    endfunction

    function automatic logic [1:0] rev2(input logic [1:0] v);
        return {v[0], v[1]};
    endfunction

    function automatic int pending();
        int s = 0;
        for (int c = 0; c < 5; c++) s += npk[c];
        return s;
    endfunction

    function automatic int qat(input int i);
        return (i < q_last.size()) ? q_last[i] : -1;
    endfunction

    task automatic drive();
        for (int c = 0; c < 5; c++) begin
            s_tvalid[c]        = (npk[c] > 0) && !hold[c];
            s_tlast[c]         = (beat[c] == plen[c] - 1);
            s_tdata[16*c +: 16] = slice(c);
            s_tkeep[2*c +: 2]   = keep_of(c);
        end
    endtask

    // One clock: check any output beat, clock, advance sources, re-drive.
    task automatic step();
        logic [4:0] fire;
        fire = s_tready & s_tvalid;
        if (m_tvalid && m_tready) begin
            nbeats++;
            check("tdata", 32'(m_tdata), 32'(rev16(slice(int'(m_tchan)))));
            check("tkeep", 32'(m_tkeep), 32'(rev2(keep_of(int'(m_tchan)))));
            if (m_tlast) q_last.push_back(int'(m_tchan));
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            if (fire[c]) begin
                if (beat[c] == plen[c] - 1) begin
                    beat[c] = 0;
                    npk[c]--;
                    pkn[c]++;
                end else begin
                    beat[c]++;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic clr_src();
        for (int c = 0; c < 5; c++) begin
            npk[c]  = 0;
            beat[c] = 0;
            pkn[c]  = 0;
            plen[c] = 1;
        end
        hold = '0;
    endtask

    task automatic do_reset();
        clr_src();
        reset = 1'b1;
        drive();
        #1;
        repeat (2) step();
        reset = 1'b0;
        drive();
        #1;
        q_last.delete();
        nbeats = 0;
    endtask

    task automatic drain(input int maxc, output int n);
        n = 0;
        while (pending() > 0 && n < maxc) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n < maxc), 32'd1);
    endtask

    int n;

    initial begin
        reset       = 1'b1;
        clear_err   = 1'b0;
        m_tready    = 1'b1;
        enable_mask = 5'b11111;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tvalid    = '0;
        s_tlast     = '0;
        nbeats      = 0;
        clr_src();

        // Reset held with a valid channel: nothing may be granted.
        npk[3]  = 1;
        plen[3] = 2;
        drive();
        #1;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_tchan", 32'(m_tchan), 32'd0);
        check("rst_err", 32'(stall_err), 32'd0);

        // Single 4-beat packet on ch2.
        do_reset();
        npk[2]  = 1;
        plen[2] = 4;
        drive();
        #1;
        check("s1_idle_busy", 32'(busy), 32'd0);
        check("s1_idle_tvalid", 32'(m_tvalid), 32'd0);
        check("s1_idle_tready", 32'(s_tready), 32'd0);
        step();
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_tready", 32'(s_tready), 32'b00100);
        for (int b = 0; b < 4; b++) begin
            check("s1_tchan", 32'(m_tchan), 32'd2);
            check("s1_tvalid", 32'(m_tvalid), 32'd1);
            check("s1_tlast", 32'(m_tlast), 32'(b == 3));
            step();
        end
        check("s1_end_busy", 32'(busy), 32'd0);
        check("s1_beats", 32'(nbeats), 32'd4);
        check("s1_lastch", 32'(qat(0)), 32'd2);
        npk[0] = 1;
        npk[3] = 1;
        npk[4] = 1;
        drive();
        #1;
        step();
        check("s1_rr3", 32'(m_tchan), 32'd3);

        // Fairness: every channel has two 2-beat packets queued.
        do_reset();
        enable_mask = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            npk[c]  = 2;
            plen[c] = 2;
        end
        drive();
        #1;
        drain(100, n);
        check("fair_cycles", 32'(n), 32'd30);
        check("fair_npkt", 32'(q_last.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("fair_order", 32'(qat(i)), 32'(i % 5));
        end

        // Masking: only channels 1, 2, 4 take part.
        do_reset();
        enable_mask = 5'b10110;
        for (int c = 0; c < 5; c++) npk[c] = 3;
        drive();
        #1;
        n = 0;
        while (q_last.size() < 4 && n < 60) begin
            step();
            n++;
        end
        check("mask_timeout", 32'(n < 60), 32'd1);
        check("mask_0", 32'(qat(0)), 32'd1);
        check("mask_1", 32'(qat(1)), 32'd2);
        check("mask_2", 32'(qat(2)), 32'd4);
        check("mask_3", 32'(qat(3)), 32'd1);

        // Backpressure on a 3-beat ch0 packet.
        do_reset();
        enable_mask = 5'b11111;
        npk[0]   = 1;
        plen[0]  = 3;
        m_tready = 1'b1;
        drive();
        #1;
        step();
        for (int i = 0; i < 5; i++) begin
            m_tready = (i % 2 == 0);
            #1;
            check("bp_tready0", 32'(s_tready[0]), 32'(m_tready));
            check("bp_others", 32'(s_tready[4:1]), 32'd0);
            check("bp_tvalid", 32'(m_tvalid), 32'd1);
            step();
        end
        m_tready = 1'b1;
        check("bp_beats", 32'(nbeats), 32'd3);
        check("bp_busy", 32'(busy), 32'd0);
        check("bp_pkts", 32'(q_last.size()), 32'd1);

        // Stall: ch3 sends one beat then goes quiet for 10 cycles.
        do_reset();
        npk[3]  = 1;
        plen[3] = 3;
        drive();
        #1;
        step();
        step();
        hold[3] = 1'b1;
        drive();
        #1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("stall_err", 32'(stall_err), (i >= 8) ? 32'b01000 : 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        hold[3] = 1'b0;
        drive();
        #1;
        drain(20, n);
        check("stall_done", 32'(busy), 32'd0);
        check("stall_beats", 32'(nbeats), 32'd3);
        check("stall_sticky", 32'(stall_err), 32'b01000);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("stall_clr", 32'(stall_err), 32'd0);

        // Reset during a 5-beat ch4 packet after rr moved to 3.
        do_reset();
        npk[2] = 1;
        drive();
        #1;
        drain(10, n);
        npk[4]  = 1;
        plen[4] = 5;
        drive();
        #1;
        step();
        step();
        check("rm_beat2", 32'(m_tvalid), 32'd1);
        reset = 1'b1;
        step();
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_tvalid", 32'(m_tvalid), 32'd0);
        check("rm_tready", 32'(s_tready), 32'd0);
        check("rm_nolast", 32'(q_last.size()), 32'd1);
        reset   = 1'b0;
        clr_src();
        npk[1]  = 1;
        npk[4]  = 1;
        drive();
        #1;
        step();
        check("rm_grant", 32'(m_tchan), 32'd1);
        check("rm_busy2", 32'(busy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
